// File: rtl/cfg_chain_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration chain loader:
//   - default geometry (columns, word width, header count field width)
//   - header field positions
//   - loader state encoding
//   - words_for(): number of data words needed to carry a bit count
// ---------------------------------------------------------------------------
package cfg_pkg;

  localparam int DEF_NUM_COLS = 2;
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_CNT_W    = 20;

  // Header layout: column select sits above the bit-count field.
  localparam int DEF_CNT_LSB  = 0;
  localparam int DEF_COL_LSB  = DEF_CNT_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SET   = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

  // ceil(cnt / word_w): data words that follow a header of cnt bits.
  function automatic int unsigned words_for(input int unsigned cnt,
                                            input int unsigned word_w);
    return (cnt + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_stream_if
// Valid/ready word stream carrying headers and data words into the loader.
//   in_data  : header or data word (producer -> loader)
//   in_valid : in_data is valid     (producer -> loader)
//   in_ready : loader accepts word  (loader -> producer)
// Modports: master = bitstream source, slave = cfg_chain_loader.
// ---------------------------------------------------------------------------
interface cfg_stream_if
  import cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/cfg_word_serializer.sv
// ---------------------------------------------------------------------------
// cfg_word_serializer
// Holds one data word and a bit index, presenting it LSB-first.
//   cclk      : config clock
//   rst       : asynchronous active-low reset
//   load      : capture load_data, index restarts at bit 0
//   load_data : word to serialize
//   advance   : step the index to the next bit
//   bit_next  : bit that will be current after this edge (word_d[idx_d]),
//               so the parent can register it in step with its own state
//   last_bit  : current index is the top bit of the word
// ---------------------------------------------------------------------------
module cfg_word_serializer
  import cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              advance,
  output logic              bit_next,
  output logic              last_bit
);

  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q,  idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = load_data;
      idx_d  = '0;
    end else if (advance) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Look-ahead bit: the parent registers it together with shift_enable.
  assign bit_next = word_d[idx_d];
  assign last_bit = (idx_q == IDX_W'(WORD_W - 1));

  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// cfg_chain_loader
// Producer end of the per-column configuration shift chains. Takes a stream
// of headers and data words, shifts each data word LSB-first into the chain
// of the column named by the header, then strobes set_hard on that column.
//   cclk          : config clock
//   rst           : asynchronous active-low reset
//   in_if         : header/data word stream (slave side)
//   shift_enable  : per-column chain shift enable
//   shift_in_hard : per-column serial config bit (0 when not shifting)
//   set_hard      : per-column one-cycle commit strobe
//   busy          : loader is not idle
//   done          : one-cycle pulse after a commit
//   err           : one-cycle pulse for a header naming a missing column
// Header: col = in_data[WORD_W-1:CNT_W], cnt = in_data[CNT_W-1:0].
// Every output is a flop whose next value is derived from the next state,
// so the chain sees a clean bit the cycle after a data word transfers.
// ---------------------------------------------------------------------------
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                cclk,
  input  logic                rst,
  cfg_stream_if.slave         in_if,
  output logic [NUM_COLS-1:0] shift_enable,
  output logic [NUM_COLS-1:0] shift_in_hard,
  output logic [NUM_COLS-1:0] set_hard,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int COL_W = WORD_W - CNT_W;

  // -------------------------------------------------------------------------
  // Header decode
  // -------------------------------------------------------------------------
  logic [COL_W-1:0]    hdr_col;
  logic [CNT_W-1:0]    hdr_cnt;
  logic                hdr_bad;
  logic [NUM_COLS-1:0] hdr_onehot;

  assign hdr_col = in_if.in_data[WORD_W-1:CNT_W];
  assign hdr_cnt = in_if.in_data[CNT_W-1:0];
  assign hdr_bad = (hdr_col >= COL_W'(NUM_COLS));

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_dec
    assign hdr_onehot[gi] = (hdr_col == COL_W'(gi));
  end

  // -------------------------------------------------------------------------
  // State and counters
  // -------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [NUM_COLS-1:0] sel_q,   sel_d;    // one-hot target column
  logic [CNT_W-1:0]    rem_q,   rem_d;    // bits left, including current
  logic [CNT_W-1:0]    drop_q,  drop_d;   // words left to discard

  // Registered outputs
  logic                in_ready_q, in_ready_d;
  logic [NUM_COLS-1:0] shift_en_q, shift_en_d;
  logic [NUM_COLS-1:0] shift_in_q, shift_in_d;
  logic [NUM_COLS-1:0] set_q,      set_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  logic xfer;
  logic ser_load;
  logic ser_adv;
  logic ser_bit_next;
  logic ser_last;

  // in_ready_q is exactly what the producer sees, so it qualifies transfers.
  assign xfer = in_if.in_valid & in_ready_q;

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .cclk      (cclk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (in_if.in_data),
    .advance   (ser_adv),
    .bit_next  (ser_bit_next),
    .last_bit  (ser_last)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    drop_d   = drop_q;
    ser_load = 1'b0;
    ser_adv  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (hdr_bad) begin
            err_d = 1'b1;
            sel_d = '0;
            if (hdr_cnt != '0) begin
              drop_d  = CNT_W'(words_for(32'(hdr_cnt), WORD_W));
              state_d = ST_DROP;
            end
          end else begin
            sel_d   = hdr_onehot;
            rem_d   = hdr_cnt;
            state_d = (hdr_cnt == '0) ? ST_SET : ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        rem_d = rem_q - CNT_W'(1);
        // Exit checks come before advancing so idx never wraps and rem
        // never underflows.
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_SET;
        end else if (ser_last) begin
          state_d = ST_LOAD;
        end else begin
          ser_adv = 1'b1;
        end
      end

      ST_SET: begin
        state_d = ST_IDLE;
      end

      ST_DROP: begin
        if (xfer) begin
          drop_d = drop_q - CNT_W'(1);
          if (drop_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output next values, derived from the state being entered
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                 (state_d == ST_DROP);
    shift_en_d = '0;
    shift_in_d = '0;
    set_d      = '0;
    if (state_d == ST_SHIFT) begin
      shift_en_d = sel_d;
      shift_in_d = sel_d & {NUM_COLS{ser_bit_next}};
    end
    if (state_d == ST_SET) begin
      set_d = sel_d;
    end
    busy_d = (state_d != ST_IDLE);
    // SET always lasts one cycle and falls back to IDLE.
    done_d = (state_q == ST_SET);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      rem_q      <= '0;
      drop_q     <= '0;
      in_ready_q <= 1'b0;
      shift_en_q <= '0;
      shift_in_q <= '0;
      set_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rem_q      <= rem_d;
      drop_q     <= drop_d;
      in_ready_q <= in_ready_d;
      shift_en_q <= shift_en_d;
      shift_in_q <= shift_in_d;
      set_q      <= set_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign shift_enable   = shift_en_q;
  assign shift_in_hard  = shift_in_q;
  assign set_hard       = set_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;

  localparam int NUM_COLS = 2;
  localparam int WORD_W   = 32;
  localparam int CNT_W    = 20;

  logic cclk = 1'b0;
  logic rst  = 1'b0;
  always #5 cclk = ~cclk;

  cfg_stream_if #(.WORD_W(WORD_W)) s_if ();

  logic [NUM_COLS-1:0] shift_enable;
  logic [NUM_COLS-1:0] shift_in_hard;
  logic [NUM_COLS-1:0] set_hard;
  logic                busy;
  logic                done;
  logic                err;

  cfg_chain_loader #(
    .NUM_COLS (NUM_COLS),
    .WORD_W   (WORD_W),
    .CNT_W    (CNT_W)
  ) dut (
    .cclk          (cclk),
    .rst           (rst),
    .in_if         (s_if),
    .shift_enable  (shift_enable),
    .shift_in_hard (shift_in_hard),
    .set_hard      (set_hard),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge cclk) cyc <= cyc + 1;

  // ---------------- monitor: records chain activity, sampled at negedge ----
  int obs_col[$];
  bit obs_bit[$];
  int obs_cyc[$];
  int set_col[$];
  int set_cyc[$];
  int done_cyc[$];
  int err_cnt = 0;
  int viol    = 0;

  always @(negedge cclk) begin
    if (rst) begin
      if ($countones(shift_enable) > 1 || $countones(set_hard) > 1) viol++;
      if ((shift_in_hard & ~shift_enable) != '0) viol++;
      if (shift_enable != '0 && set_hard != '0) viol++;
      for (int c = 0; c < NUM_COLS; c++) begin
        if (shift_enable[c]) begin
          obs_col.push_back(c);
          obs_bit.push_back(shift_in_hard[c]);
          obs_cyc.push_back(cyc);
        end
        if (set_hard[c]) begin
          set_col.push_back(c);
          set_cyc.push_back(cyc);
        end
      end
      if (done) done_cyc.push_back(cyc);
      if (err) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking besides bounded waits) ---
  logic [31:0] tx_words [0:7];
  int xc_hdr;
  int xcs [0:7];
  int b_bit, b_set, b_done, b_err;

  task automatic send_word(input logic [31:0] w, output int xcyc);
    int t;
    t = 0;
    s_if.in_data  = w;
    s_if.in_valid = 1'b1;
    while (!s_if.in_ready && t < 300) begin
      @(negedge cclk);
      t++;
    end
    if (t >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles required 1", t);
      s_if.in_valid = 1'b0;
      xcyc = -1;
      return;
    end
    @(posedge cclk);
    @(negedge cclk);
    xcyc = cyc;
    s_if.in_valid = 1'b0;
    s_if.in_data  = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3000) begin
      @(negedge cclk);
      t++;
    end
    if (t >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 required 0");
    end
    repeat (2) @(negedge cclk);
  endtask

  task automatic mark_bases();
    b_bit  = obs_bit.size();
    b_set  = set_col.size();
    b_done = done_cyc.size();
    b_err  = err_cnt;
  endtask

  task automatic drive_txn(input int col, input int cnt, input int gap_max);
    logic [31:0] hdr;
    int nw;
    int xc;
    mark_bases();
    hdr = {12'(col), 20'(cnt)};
    send_word(hdr, xc);
    xc_hdr = xc;
    nw = (cnt + 31) / 32;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge cclk);
      send_word(tx_words[i], xc);
      xcs[i] = xc;
    end
    wait_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3*NUM_COLS+3:0] outs;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    rst = 1'b0;
    repeat (3) @(negedge cclk);
    outs = {s_if.in_ready, shift_enable, shift_in_hard, set_hard, busy, done, err};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst = 1'b1;
    @(negedge cclk);
    n_tests++;
    if (s_if.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b required ready=1 busy=0", s_if.in_ready, busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] got;
    int nb, wrong_col;
    tx_words[0] = 32'h0000_00A5;
    drive_txn(1, 8, 0);
    nb = obs_bit.size() - b_bit;
    n_tests++;
    if (nb != 8) begin
      n_fail++;
      $display("FAIL single_bitcount: got %0d required 8", nb);
    end else begin
      got = '0;
      wrong_col = 0;
      for (int i = 0; i < 8; i++) begin
        got[i] = obs_bit[b_bit+i];
        if (obs_col[b_bit+i] != 1) wrong_col++;
      end
      n_tests++;
      if (got !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_bits: got %h required a5", got);
      end
      n_tests++;
      if (wrong_col != 0) begin
        n_fail++;
        $display("FAIL single_column: got %0d bits on wrong column required 0", wrong_col);
      end
      n_tests++;
      if (obs_cyc[b_bit] != xcs[0] || obs_cyc[b_bit+7] != xcs[0] + 7) begin
        n_fail++;
        $display("FAIL single_timing: got first=%0d last=%0d required %0d..%0d",
                 obs_cyc[b_bit], obs_cyc[b_bit+7], xcs[0], xcs[0] + 7);
      end
      n_tests++;
      if (set_col.size() - b_set != 1 || set_col[b_set] != 1 ||
          set_cyc[b_set] != obs_cyc[b_bit+7] + 1) begin
        n_fail++;
        $display("FAIL single_set: got %0d pulses required 1 on col 1 right after last bit",
                 set_col.size() - b_set);
      end else begin
        n_tests++;
        if (done_cyc.size() - b_done != 1 || done_cyc[b_done] != set_cyc[b_set] + 1) begin
          n_fail++;
          $display("FAIL single_done: got %0d pulses required 1 the cycle after set",
                   done_cyc.size() - b_done);
        end
      end
    end
  endtask

  task automatic test_multi_word();
    int nb, ones;
    logic [7:0] tail;
    tx_words[0] = 32'hFFFF_FFFF;
    tx_words[1] = 32'h0000_0055;
    drive_txn(0, 40, 2);
    nb = obs_bit.size() - b_bit;
    n_tests++;
    if (nb != 40) begin
      n_fail++;
      $display("FAIL multi_bitcount: got %0d required 40", nb);
    end else begin
      ones = 0;
      for (int i = 0; i < 32; i++) if (obs_bit[b_bit+i]) ones++;
      for (int i = 0; i < 8; i++) tail[i] = obs_bit[b_bit+32+i];
      n_tests++;
      if (ones != 32 || tail !== 8'h55) begin
        n_fail++;
        $display("FAIL multi_bits: got ones=%0d tail=%h required 32 and 55", ones, tail);
      end
      n_tests++;
      if (obs_cyc[b_bit+32] <= obs_cyc[b_bit+31] + 1) begin
        n_fail++;
        $display("FAIL multi_gap: got word gap %0d cycles required >1",
                 obs_cyc[b_bit+32] - obs_cyc[b_bit+31]);
      end
    end
    n_tests++;
    if (set_col.size() - b_set != 1 || (set_col.size() > b_set && set_col[b_set] != 0)) begin
      n_fail++;
      $display("FAIL multi_set: got %0d pulses required 1 on col 0", set_col.size() - b_set);
    end
  endtask

  task automatic test_drop();
    int b_set0, b_bit0;
    tx_words[0] = $urandom;
    tx_words[1] = $urandom;
    b_bit0 = obs_bit.size();
    b_set0 = set_col.size();
    drive_txn(3, 33, 1);
    n_tests++;
    if (err_cnt - b_err != 1) begin
      n_fail++;
      $display("FAIL drop_err: got %0d pulses required 1", err_cnt - b_err);
    end
    n_tests++;
    if (xcs[0] < 0 || xcs[1] < 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_consume: got accepted=%0d,%0d busy=%b required both words and idle",
               xcs[0], xcs[1], busy);
    end
    n_tests++;
    if (obs_bit.size() != b_bit0 || set_col.size() != b_set0 || done_cyc.size() != b_done) begin
      n_fail++;
      $display("FAIL drop_quiet: got bits=%0d sets=%0d dones=%0d required 0",
               obs_bit.size() - b_bit0, set_col.size() - b_set0, done_cyc.size() - b_done);
    end
    // Next header goes straight through as a commit-only on column 1.
    drive_txn(1, 0, 0);
    n_tests++;
    if (set_col.size() - b_set != 1 || (set_col.size() > b_set && set_col[b_set] != 1)) begin
      n_fail++;
      $display("FAIL drop_next_hdr: got %0d set pulses required 1 on col 1", set_col.size() - b_set);
    end
  endtask

  task automatic test_commit_only();
    drive_txn(0, 0, 0);
    n_tests++;
    if (obs_bit.size() != b_bit) begin
      n_fail++;
      $display("FAIL commit_noshift: got %0d bits required 0", obs_bit.size() - b_bit);
    end
    n_tests++;
    if (set_col.size() - b_set != 1 || set_col[b_set] != 0 || set_cyc[b_set] != xc_hdr) begin
      n_fail++;
      $display("FAIL commit_set: got %0d pulses required 1 on col 0 the cycle after header",
               set_col.size() - b_set);
    end else begin
      n_tests++;
      if (done_cyc.size() - b_done != 1 || done_cyc[b_done] != xc_hdr + 1) begin
        n_fail++;
        $display("FAIL commit_done: got %0d pulses required 1 after set", done_cyc.size() - b_done);
      end
    end
  endtask

  task automatic test_backpressure();
    int xc, good_cyc, nb, wrong;
    logic [31:0] w;
    w = $urandom;
    mark_bases();
    send_word({12'd1, 20'd12}, xc);
    good_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_if.in_ready === 1'b1 && shift_enable === '0 && busy === 1'b1) good_cyc++;
      @(negedge cclk);
    end
    n_tests++;
    if (good_cyc != 5) begin
      n_fail++;
      $display("FAIL bp_wait_load: got %0d good wait cycles required 5", good_cyc);
    end
    send_word(w, xc);
    wait_idle();
    nb = obs_bit.size() - b_bit;
    wrong = 0;
    for (int i = 0; i < nb && i < 12; i++)
      if (obs_bit[b_bit+i] !== w[i] || obs_col[b_bit+i] != 1) wrong++;
    n_tests++;
    if (nb != 12 || wrong != 0 || obs_cyc[b_bit] != xc) begin
      n_fail++;
      $display("FAIL bp_bits: got %0d bits %0d wrong required 12 correct bits after data", nb, wrong);
    end
  endtask

  task automatic test_reset_mid();
    int xc, t, nb, wrong;
    logic [3*NUM_COLS+3:0] outs;
    tx_words[0] = $urandom;
    mark_bases();
    send_word({12'd0, 20'd32}, xc);
    send_word(tx_words[0], xc);
    t = 0;
    while (obs_bit.size() - b_bit < 10 && t < 100) begin
      @(negedge cclk);
      t++;
    end
    @(posedge cclk);
    #2;
    rst = 1'b0;
    #1;
    outs = {s_if.in_ready, shift_enable, shift_in_hard, set_hard, busy, done, err};
    n_tests++;
    if (outs !== '0 || t >= 100) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got %h (wait %0d) required 0", outs, t);
    end
    repeat (3) @(negedge cclk);
    outs = {s_if.in_ready, shift_enable, shift_in_hard, set_hard, busy, done, err};
    n_tests++;
    if (outs !== '0 || set_col.size() != b_set || done_cyc.size() != b_done || err_cnt != b_err) begin
      n_fail++;
      $display("FAIL rst_mid_nocommit: got outs=%h sets=%0d dones=%0d errs=%0d required all 0",
               outs, set_col.size() - b_set, done_cyc.size() - b_done, err_cnt - b_err);
    end
    rst = 1'b1;
    @(negedge cclk);
    n_tests++;
    if (s_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got %b required 1", s_if.in_ready);
    end
    tx_words[0] = $urandom;
    drive_txn(1, 4, 1);
    nb = obs_bit.size() - b_bit;
    wrong = 0;
    for (int i = 0; i < nb && i < 4; i++)
      if (obs_bit[b_bit+i] !== tx_words[0][i] || obs_col[b_bit+i] != 1) wrong++;
    n_tests++;
    if (nb != 4 || wrong != 0 || set_col.size() - b_set != 1 || done_cyc.size() - b_done != 1) begin
      n_fail++;
      $display("FAIL rst_mid_recover: got bits=%0d wrong=%0d sets=%0d dones=%0d required 4,0,1,1",
               nb, wrong, set_col.size() - b_set, done_cyc.size() - b_done);
    end
  endtask

  task automatic test_random();
    int col, cnt, nb, exp_nb, wrong, nsets, ndone, nerr, starts_bad;
    bit good;
    for (int k = 0; k < 25; k++) begin
      col = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0:       cnt = 0;
        1:       cnt = 1;
        2:       cnt = 32;
        3:       cnt = 33;
        4:       cnt = 64;
        default: cnt = $urandom_range(2, 200);
      endcase
      for (int i = 0; i < 8; i++) tx_words[i] = $urandom;
      drive_txn(col, cnt, 3);
      // Reference: a good header puts bit i of the concatenated words
      // (word i/32, bit i%32) on its column for i < cnt, then one commit.
      good   = (col < NUM_COLS);
      exp_nb = good ? cnt : 0;
      nb     = obs_bit.size() - b_bit;
      nsets  = set_col.size() - b_set;
      ndone  = done_cyc.size() - b_done;
      nerr   = err_cnt - b_err;
      n_tests++;
      if (nb != exp_nb) begin
        n_fail++;
        $display("FAIL rnd_bitcount[%0d]: got %0d required %0d (col=%0d cnt=%0d)", k, nb, exp_nb, col, cnt);
      end
      wrong = 0;
      starts_bad = 0;
      for (int i = 0; i < nb && i < exp_nb; i++) begin
        if (obs_bit[b_bit+i] !== tx_words[i/32][i%32] || obs_col[b_bit+i] != col) wrong++;
        if (i % 32 == 0 && obs_cyc[b_bit+i] != xcs[i/32]) starts_bad++;
      end
      n_tests++;
      if (wrong != 0 || starts_bad != 0) begin
        n_fail++;
        $display("FAIL rnd_bits[%0d]: got %0d wrong bits %0d late words required 0", k, wrong, starts_bad);
      end
      n_tests++;
      if (nsets != (good ? 1 : 0) || ndone != (good ? 1 : 0) || nerr != (good ? 0 : 1)) begin
        n_fail++;
        $display("FAIL rnd_pulses[%0d]: got set=%0d done=%0d err=%0d required %0d,%0d,%0d",
                 k, nsets, ndone, nerr, good ? 1 : 0, good ? 1 : 0, good ? 0 : 1);
      end
      if (good && nsets == 1 && ndone == 1 && nb == exp_nb) begin
        n_tests++;
        if (set_col[b_set] != col ||
            set_cyc[b_set] != ((cnt == 0) ? xc_hdr : obs_cyc[b_bit+cnt-1] + 1) ||
            done_cyc[b_done] != set_cyc[b_set] + 1) begin
          n_fail++;
          $display("FAIL rnd_commit[%0d]: got set col %0d at %0d done at %0d", k,
                   set_col[b_set], set_cyc[b_set], done_cyc[b_done]);
        end
      end
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL chain_rules: got %0d violating cycles required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_word();
    test_drop();
    test_commit_only();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Producer end of the per-column configuration shift chains consumed by fpga_clb_tiles: shift_enable, shift_in_hard and set_hard, one bit per column.
- Accepts a valid/ready word stream made of headers followed by data words, serializes each data word LSB-first into the selected column's chain, then pulses set_hard for that column to commit the shifted configuration.
- Runs in the config clock domain (cclk) and sits between the bitstream source (host interface or ROM) and the fabric.

Parameters:
- NUM_COLS, 2, number of fabric columns (one chain each).
- WORD_W, 32, input word width.
- CNT_W, 20, width of the bit-count field in the header; the column field is bits [WORD_W-1:CNT_W].

Ports:
- cclk  in  1  config clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  WORD_W  header or data word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts the word this cycle.
- shift_enable  out  NUM_COLS  per-column chain shift enable.
- shift_in_hard  out  NUM_COLS  per-column serial config bit.
- set_hard  out  NUM_COLS  per-column commit strobe.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a commit completes.
- err  out  1  one-cycle pulse when a header selects a column >= NUM_COLS.

Behaviour:
- Handshake: a word transfers on a rising cclk edge with in_valid & in_ready. in_data is sampled only on a transfer. in_valid may drop at any time without effect.
- All outputs are registered.
- Reset: while rst is low, every output is 0 and state is IDLE. In the first cycle after release, in_ready = 1.
- Header format: col = in_data[WORD_W-1:CNT_W], cnt = in_data[CNT_W-1:0] (bits to shift).
- IDLE (in_ready = 1): on header transfer:
  - col >= NUM_COLS: err pulses the next cycle; if cnt > 0, go to DROP, else stay in IDLE.
  - cnt == 0: go to SET (commit only).
  - Otherwise: latch col and cnt into rem, go to LOAD.
- LOAD (in_ready = 1): on data transfer, latch the word, bit index = 0, go to SHIFT.
- SHIFT (in_ready = 0): each cycle, shift_enable[col] = 1 and shift_in_hard[col] = word[idx]. idx and rem both advance by 1.
  - The first bit appears the cycle after the data transfer.
  - Leave SHIFT when idx reaches WORD_W-1 or rem reaches 1:
    - rem becomes 0: go to SET.
    - Otherwise: go to LOAD.
  - At least one cycle with shift_enable low separates consecutive words.
- The final partial word uses only its low rem bits; the upper bits are ignored.
- SET: set_hard[col] = 1 for exactly one cycle, and shift_enable stays 0. The following cycle, done = 1 and the state returns to IDLE.
- DROP (in_ready = 1): consume ceil(cnt/WORD_W) data words, drive no chain outputs, then return to IDLE.
- Non-selected columns: shift_enable, shift_in_hard and set_hard stay 0 at all times.
- shift_in_hard[col] returns to 0 whenever its shift_enable is 0.
- At most one shift_enable bit and one set_hard bit are high in any cycle.
- Reset mid-operation: outputs clear asynchronously. Partially shifted chains are never committed. No done or err pulse is produced.
- Counters: rem is CNT_W bits; idx is clog2(WORD_W) bits. Neither wraps, because the exit conditions above are checked first.

Decomposition:
- Shared package cfg_pkg holds:
  - header field positions (CNT_W, column field LSB);
  - the state encoding (IDLE, LOAD, SHIFT, SET, DROP);
  - a function for words-per-count, ceil(cnt/WORD_W).
- One natural sub-module: cfg_word_serializer (word register, idx counter, LSB-first bit output, last-bit flag). The FSM, column decode and DROP counter stay in the top level.

Test Plan:
- Reset then header col=1 cnt=8, data 0x000000A5:
  - shift_enable[1] is high for exactly 8 cycles; shift_in_hard[1] carries 1,0,1,0,0,1,0,1.
  - Then set_hard[1] pulses for 1 cycle, done pulses the next cycle, and column 0 stays 0 throughout.
- Header col=0 cnt=40, data 0xFFFFFFFF then 0x00000055:
  - 32 ones are shifted, then a gap of ≥1 cycle with enable low, then 8 bits 1,0,1,0,1,0,1,0.
  - set_hard[0] pulses once; the total count of enable-high cycles is 40.
- Header col=3 cnt=33 (NUM_COLS=2):
  - err pulses once; 2 data words are accepted and discarded.
  - No shift_enable or set_hard activity; the next header is accepted in IDLE.
- Header col=0 cnt=0:
  - No shift; set_hard[0] pulses the next cycle, then done.
- Backpressure: hold in_valid low for 5 cycles between header and data:
  - The loader waits in LOAD with in_ready = 1 and no enables; the bit sequence is unchanged.
- Assert rst during bit 10 of a 32-bit load:
  - All outputs go 0 immediately; set_hard and done never pulse.
  - After release, a fresh header col=1 cnt=4 completes normally.
